vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Upstream timing stage for the pong display path. Derives a 25 MHz pixel enable from the 100 MHz board clock.
- Generates 640x480@60 raster counters, hSync/vSync and the bright (active-video) flag. The pixel colour stage consumes hCount/vCount/bright; this block drives the VGA connector syncs.
- Also emits line, frame and vblank strobes so game logic (paddle/ball update) can run once per frame, outside active video.

Parameters:
- DIV, 4, clk cycles per pixel (power of two; 100 MHz / 4 = 25 MHz)
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hSync low width in pixels, starting at hCount 0
- H_ACT_START, 144, first active hCount
- H_ACT_END, 783, last active hCount
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vSync low width in lines, starting at vCount 0
- V_ACT_START, 35, first active vCount
- V_ACT_END, 514, last active vCount

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  out  1  one-clk-wide pixel enable, every DIV clks
- hCount  out  10  horizontal position, 0..H_TOTAL-1
- vCount  out  10  vertical position, 0..V_TOTAL-1
- hSync  out  1  horizontal sync, active low
- vSync  out  1  vertical sync, active low
- bright  out  1  high inside the active window
- line_tick  out  1  one-clk pulse when hCount becomes 0
- frame_tick  out  1  one-clk pulse when (hCount,vCount) becomes (0,0)
- vblank_tick  out  1  one-clk pulse when vCount becomes V_ACT_END+1 with hCount 0
- frame_count  out  16  frames completed since reset, wraps

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high: div, hCount, vCount, frame_count = 0; pix_en, bright, all ticks = 0; hSync = 0, vSync = 0 (position 0 lies inside both sync pulses).
  - Asserting rst mid-frame restarts immediately. There is no partial-frame flush.
- Divider:
  - log2(DIV)-bit counter increments every clk and wraps DIV-1 -> 0.
  - pix_en is registered. It is high for exactly the one clk in which div == DIV-1.
  - After reset release, pix_en first rises after edge 3 (DIV=4) and repeats with a period of DIV clks.
- Counters advance only on clk edges where pix_en == 1:
  - hCount: if hCount == H_TOTAL-1, go to 0 and advance vCount; otherwise hCount+1.
  - vCount: if vCount == V_TOTAL-1, go to 0 and increment frame_count; otherwise vCount+1.
  - hCount increments by exactly 1 per DIV clks. Line = 3200 clk; frame = 1,680,000 clk.
- Decoded outputs are registered in the same edge as the counters and computed from the next counter values, so they are always consistent with the hCount/vCount currently presented. There is no pipeline skew between counts and flags.
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
  - bright = H_ACT_START <= hCount <= H_ACT_END and V_ACT_START <= vCount <= V_ACT_END (inclusive bounds)
- Ticks:
  - Each tick is high for exactly one clk: the clk immediately following the advancing edge that produced the qualifying position.
  - A tick never repeats during the remaining DIV-1 clks of that pixel.
  - frame_tick implies line_tick in the same cycle.
  - vblank_tick coincides with line_tick.
  - No tick is emitted out of reset: position (0,0) after reset does not pulse frame_tick. The first frame_tick comes at the first wrap.
- Width rules:
  - All comparisons are unsigned 10-bit.
  - frame_count wraps from 0xFFFF to 0 silently.
  - Parameters must satisfy H_ACT_END < H_TOTAL and V_ACT_END < V_TOTAL. Check this with an elaboration-time error.

Decomposition:
- Package vga_timing_pkg: default timing constants (H_*, V_*, DIV) and a 10-bit coordinate width constant. These are shared with the pixel colour stage and the game logic.
- Sub-module clk_en_div (parameter DIV): holds the divider counter and registered pix_en.
- The counters, sync/bright decode and tick logic stay in vga_sync_gen.

Test Plan:
- Reset release: rst high 5 clks then low -> all outputs 0 during reset; first pix_en in the clk after edge 3; hCount == 1 after edge 4; hCount == 2 after edge 8.
- Line wrap: run to hCount 799, vCount 0 -> next advance gives hCount 0, vCount 1; line_tick for 1 clk; frame_tick stays 0.
- Sync/bright edges:
  - hSync is 0 for hCount 0..95 and 1 at 96.
  - bright rises at (144,35) and falls at (784,35); bright stays 0 at (144,34) and (144,515).
  - vSync is low only on lines 0..1.
- Frame wrap: run 1,680,000 clks -> (0,0) reached; frame_tick and line_tick high together for 1 clk; frame_count == 1; vblank_tick was seen once, at (0,515).
- Mid-frame reset: pulse rst for 1 clk at (400,200) -> outputs are 0 asynchronously, before the next clk edge; the counting sequence restarts identically to the reset-release case.
- Long run: 65,536 frames (or force frame_count near wrap) -> frame_count wraps 0xFFFF -> 0; exactly one frame_tick per 1,680,000 clks; no tick ever lasts longer than 1 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants shared by the display path
// Contents: COORD_W (raster coordinate width), VGA_DIV (clk cycles per pixel),
//           VGA_H_* / VGA_V_* line and frame geometry.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_DIV = 4;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 783;

    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 514;

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - free-running clock divider producing a one-clk pixel enable
// Ports: clk    - system clock
//        rst    - asynchronous active-high reset
//        pix_en - registered, high for the one clk in which the divider sits at DIV-1
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 2 || (DIV & (DIV - 1)) != 0) begin : g_bad_div
        $error("clk_en_div: DIV must be a power of two and at least 2");
    end

    logic [W-1:0] div;
    logic [W-1:0] div_next;

    // The counter width matches log2(DIV), so the natural overflow is the wrap.
    assign div_next = div + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= div_next;
            pix_en <= (div_next == LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster counters, sync/bright decode and line/frame/vblank strobes
// Ports: clk, rst (async active-high)
//        pix_en      - pixel enable, one clk every DIV clks
//        hCount      - horizontal position 0..H_TOTAL-1
//        vCount      - vertical position 0..V_TOTAL-1
//        hSync/vSync - active-low syncs, low from position 0 for H_SYNC pixels / V_SYNC lines
//        bright      - inside the inclusive active window
//        line_tick   - one clk after hCount becomes 0
//        frame_tick  - one clk after (hCount,vCount) becomes (0,0)
//        vblank_tick - one clk after vCount becomes V_ACT_END+1 at hCount 0
//        frame_count - frames completed since reset, wrapping
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int DIV         = VGA_DIV,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_en,
    output logic [COORD_W-1:0] hCount,
    output logic [COORD_W-1:0] vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic               line_tick,
    output logic               frame_tick,
    output logic               vblank_tick,
    output logic [15:0]        frame_count
);

    if (H_ACT_END >= H_TOTAL) begin : g_bad_h
        $error("vga_sync_gen: H_ACT_END must be below H_TOTAL");
    end
    if (V_ACT_END >= V_TOTAL) begin : g_bad_v
        $error("vga_sync_gen: V_ACT_END must be below V_TOTAL");
    end
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_w
        $error("vga_sync_gen: totals must fit the coordinate width");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_SYNC_L = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_L = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] H_ACT_S  = COORD_W'(H_ACT_START);
    localparam logic [COORD_W-1:0] H_ACT_E  = COORD_W'(H_ACT_END);
    localparam logic [COORD_W-1:0] V_ACT_S  = COORD_W'(V_ACT_START);
    localparam logic [COORD_W-1:0] V_ACT_E  = COORD_W'(V_ACT_END);
    localparam logic [COORD_W-1:0] V_BLANK  = COORD_W'(V_ACT_END + 1);
    // When the active window reaches the last line there is no blanking line to flag.
    localparam logic               HAS_VBLANK = (V_ACT_END + 1 < V_TOTAL);
    localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);

    clk_en_div #(
        .DIV(DIV)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .pix_en(pix_en)
    );

    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic [15:0]        fc_next;
    logic               h_wrap;
    logic               v_wrap;

    always_comb begin
        h_next  = hCount;
        v_next  = vCount;
        fc_next = frame_count;
        h_wrap  = 1'b0;
        v_wrap  = 1'b0;
        if (pix_en) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                h_wrap = 1'b1;
                if (vCount == V_LAST) begin
                    v_next  = '0;
                    v_wrap  = 1'b1;
                    fc_next = frame_count + 16'd1;
                end else begin
                    v_next = vCount + C_ONE;
                end
            end else begin
                h_next = hCount + C_ONE;
            end
        end
    end

    // Flags decode the next counter values so they line up with the counts
    // presented in the same cycle. Ticks key off the wrap itself, which only
    // happens on a pix_en edge, so they cannot repeat within one pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount      <= '0;
            vCount      <= '0;
            frame_count <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            vblank_tick <= 1'b0;
        end else begin
            hCount      <= h_next;
            vCount      <= v_next;
            frame_count <= fc_next;
            hSync       <= !(h_next < H_SYNC_L);
            vSync       <= !(v_next < V_SYNC_L);
            bright      <= (h_next >= H_ACT_S) && (h_next <= H_ACT_E) &&
                           (v_next >= V_ACT_S) && (v_next <= V_ACT_E);
            line_tick   <= h_wrap;
            frame_tick  <= h_wrap && v_wrap;
            vblank_tick <= h_wrap && HAS_VBLANK && (v_next == V_BLANK);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and reduced geometry)
module tb_vga_sync_gen;

    typedef struct packed {
        logic        pix_en;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        lt;
        logic        ft;
        logic        vt;
        logic [15:0] fc;
    } obs_t;

    localparam int DIVT = 4;
    // reduced geometry keeps several whole frames inside a short run
    localparam int S_HT = 40, S_HS = 5, S_HAS = 8, S_HAE = 35;
    localparam int S_VT = 20, S_VS = 2, S_VAS = 4, S_VAE = 17;
    localparam int S_FRAME = S_HT * S_VT * DIVT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       s_pix_en, s_hs, s_vs, s_br, s_lt, s_ft, s_vt;
    logic [9:0] s_h, s_v;
    logic [15:0] s_fc;
    logic       d_pix_en, d_hs, d_vs, d_br, d_lt, d_ft, d_vt;
    logic [9:0] d_h, d_v;
    logic [15:0] d_fc;

    obs_t obs_s, obs_d, exp_s, exp_d;

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .DIV(DIVT), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HAS), .H_ACT_END(S_HAE),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(s_pix_en), .hCount(s_h), .vCount(s_v),
        .hSync(s_hs), .vSync(s_vs), .bright(s_br), .line_tick(s_lt),
        .frame_tick(s_ft), .vblank_tick(s_vt), .frame_count(s_fc)
    );

    vga_sync_gen u_def (
        .clk(clk), .rst(rst), .pix_en(d_pix_en), .hCount(d_h), .vCount(d_v),
        .hSync(d_hs), .vSync(d_vs), .bright(d_br), .line_tick(d_lt),
        .frame_tick(d_ft), .vblank_tick(d_vt), .frame_count(d_fc)
    );

    assign obs_s = {s_pix_en, s_h, s_v, s_hs, s_vs, s_br, s_lt, s_ft, s_vt, s_fc};
    assign obs_d = {d_pix_en, d_h, d_v, d_hs, d_vs, d_br, d_lt, d_ft, d_vt, d_fc};

    // Expected outputs after kk clk edges since reset release: every DIV clks
    // one pixel elapses, and position/frames follow from the pixel count.
    function automatic obs_t model(input int kk, input int ht, input int hsw, input int has,
                                   input int hae, input int vtot, input int vsw,
                                   input int vas, input int vae);
        obs_t o;
        int n, h, v, fr;
        logic edge_px;
        n  = kk / DIVT;
        h  = n % ht;
        v  = (n / ht) % vtot;
        fr = n / (ht * vtot);
        edge_px  = (kk > 0) && (kk % DIVT == 0);
        o.pix_en = (kk % DIVT) == DIVT - 1;
        o.h      = 10'(h);
        o.v      = 10'(v);
        o.hs     = (h >= hsw);
        o.vs     = (v >= vsw);
        o.br     = (h >= has) && (h <= hae) && (v >= vas) && (v <= vae);
        o.lt     = edge_px && (h == 0);
        o.ft     = edge_px && (h == 0) && (v == 0);
        o.vt     = edge_px && (h == 0) && (v == vae + 1);
        o.fc     = 16'(fr);
        return o;
    endfunction

    function automatic obs_t model_s(input int kk);
        return model(kk, S_HT, S_HS, S_HAS, S_HAE, S_VT, S_VS, S_VAS, S_VAE);
    endfunction

    function automatic obs_t model_d(input int kk);
        return model(kk, 800, 96, 144, 783, 525, 2, 35, 514);
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1;
        n = $urandom_range(3, 8);
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (obs_s !== '0) begin
                errors++;
                $display("FAIL reset_small got=%h exp=0", obs_s);
            end
            checks++;
            if (obs_d !== '0) begin
                errors++;
                $display("FAIL reset_def got=%h exp=0", obs_d);
            end
        end
    endtask

    task automatic test_reset_release(input string tag);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
                k++;
            end
            exp_s = model_s(k);
            exp_d = model_d(k);
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL %s_small k=%0d got=%h exp=%h", tag, k, obs_s, exp_s);
            end
            checks++;
            if (obs_d !== exp_d) begin
                errors++;
                $display("FAIL %s_def k=%0d got=%h exp=%h", tag, k, obs_d, exp_d);
            end
            if (k == 3) begin
                checks++;
                if (d_pix_en !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_first_pix_en got=%b exp=1", tag, d_pix_en);
                end
            end
            if (k == 4 || k == 8) begin
                checks++;
                if (d_h !== 10'(k / 4)) begin
                    errors++;
                    $display("FAIL %s_hcount k=%0d got=%0d exp=%0d", tag, k, d_h, k / 4);
                end
            end
        end
    endtask

    task automatic test_run_frames();
        int target, n_line, n_frame, n_vbl, px, exp_vbl;
        logic hs95, hs96, vs1, vs2;
        n_line = 0; n_frame = 0; n_vbl = 0;
        hs95 = 1'bx; hs96 = 1'bx; vs1 = 1'bx; vs2 = 1'bx;
        target = 3 * S_FRAME + $urandom_range(0, 400);
        while (k < target) begin
            @(negedge clk);
            k++;
            exp_s = model_s(k);
            exp_d = model_d(k);
            checks++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL run_small k=%0d got=%h exp=%h", k, obs_s, exp_s);
            end
            checks++;
            if (obs_d !== exp_d) begin
                errors++;
                $display("FAIL run_def k=%0d got=%h exp=%h", k, obs_d, exp_d);
            end
            if (s_lt) n_line++;
            if (s_ft) n_frame++;
            if (s_vt) begin
                n_vbl++;
                checks++;
                if (s_h !== 10'd0 || s_v !== 10'(S_VAE + 1)) begin
                    errors++;
                    $display("FAIL vblank_pos got=(%0d,%0d) exp=(0,%0d)", s_h, s_v, S_VAE + 1);
                end
            end
            if (d_v == 10'd0 && d_h == 10'd95) hs95 = d_hs;
            if (d_v == 10'd0 && d_h == 10'd96) hs96 = d_hs;
            if (d_v == 10'd1) vs1 = d_vs;
            if (d_v == 10'd2) vs2 = d_vs;
        end
        px = k / DIVT;
        exp_vbl = (px >= S_HT * (S_VAE + 1)) ? (px - S_HT * (S_VAE + 1)) / (S_HT * S_VT) + 1 : 0;
        checks++;
        if (n_frame !== px / (S_HT * S_VT)) begin
            errors++;
            $display("FAIL frame_tick_count got=%0d exp=%0d", n_frame, px / (S_HT * S_VT));
        end
        checks++;
        if (n_line !== px / S_HT) begin
            errors++;
            $display("FAIL line_tick_count got=%0d exp=%0d", n_line, px / S_HT);
        end
        checks++;
        if (n_vbl !== exp_vbl) begin
            errors++;
            $display("FAIL vblank_tick_count got=%0d exp=%0d", n_vbl, exp_vbl);
        end
        checks++;
        if (hs95 !== 1'b0 || hs96 !== 1'b1) begin
            errors++;
            $display("FAIL hsync_edge got=%b%b exp=01", hs95, hs96);
        end
        checks++;
        if (vs1 !== 1'b0 || vs2 !== 1'b1) begin
            errors++;
            $display("FAIL vsync_edge got=%b%b exp=01", vs1, vs2);
        end
    endtask

    task automatic test_mid_frame_reset();
        int stop_k;
        stop_k = k + $urandom_range(200, 2500);
        while (k < stop_k) begin
            @(negedge clk);
            k++;
            exp_s = model_s(k);
            exp_d = model_d(k);
            checks++;
            if (obs_s !== exp_s || obs_d !== exp_d) begin
                errors++;
                $display("FAIL pre_reset k=%0d got=%h/%h exp=%h/%h", k, obs_s, obs_d, exp_s, exp_d);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_s !== '0 || obs_d !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h/%h exp=0", obs_s, obs_d);
        end
        @(negedge clk);
        checks++;
        if (obs_s !== '0 || obs_d !== '0) begin
            errors++;
            $display("FAIL held_reset got=%h/%h exp=0", obs_s, obs_d);
        end
        test_reset_release("restart");
    endtask

    initial begin
        test_reset();
        test_reset_release("release");
        test_run_frames();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
